ready_pool: RTL and testbench

Fixed-depth entry pool that buffers tagged payloads until they are woken up, then issues one ready entry per cycle under a valid/ready handshake. It sits directly upstream of the bitmap-mode `selector`. It builds the per-entry payload vector and the ready bitmap that `selector` arbitrates, and consumes the resulting one-hot `pos` to release the issued slot. Typical use is as a small issue queue or wait buffer in front of a functional unit.

---
 rtl/ready_pool_pkg.sv | 20 ++
 rtl/selector.sv | 48 ++++
 rtl/ready_pool.sv | 133 +++++++++++++
 tb/tb_ready_pool.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ready_pool_pkg.sv
// Shared types and selector mode constants for the ready_pool issue buffer.
package ready_pool_pkg;

  localparam int unsigned PkgData = 32;
  localparam int unsigned PkgTag  = 6;

  // Selector mode encodings.
  localparam bit Enable  = 1'b1;
  localparam bit Disable = 1'b0;
  localparam bit High    = 1'b1;
  localparam bit Low     = 1'b0;

  typedef struct packed {
    logic              vld;
    logic              rdy;
    logic [PkgTag-1:0] tag;
    logic [PkgData-1:0] data;
  } entry_t;

endpackage

// File: rtl/selector.sv
// Priority selector: one-hot pick from a request bitmap plus an AND-OR data mux.
module selector
  import ready_pool_pkg::*;
#(
  parameter bit          BIT_MAP = Enable,
  parameter bit          ACT     = High,
  parameter bit          MSB     = Disable,
  parameter int unsigned DATA    = 32,
  parameter int unsigned IN      = 8
) (
  input  logic [IN-1:0]      i_req,
  input  logic [IN*DATA-1:0] i_data,
  output logic [IN-1:0]      o_pos,
  output logic               o_valid,
  output logic [DATA-1:0]    o_data
);

  logic [IN-1:0] w_act;

  always_comb begin
    w_act = ACT ? i_req : ~i_req;
    o_pos = '0;
    if (!BIT_MAP) begin
      // Non-bitmap mode: request is already a one-hot position.
      o_pos = w_act;
    end else if (MSB) begin
      for (int i = 0; i < int'(IN); i++) begin
        if (w_act[i]) begin
          o_pos    = '0;
          o_pos[i] = 1'b1;
        end
      end
    end else begin
      for (int i = int'(IN) - 1; i >= 0; i--) begin
        if (w_act[i]) begin
          o_pos    = '0;
          o_pos[i] = 1'b1;
        end
      end
    end
    o_valid = |w_act;
    o_data  = '0;
    for (int i = 0; i < int'(IN); i++) begin
      if (o_pos[i]) o_data = o_data | i_data[i*DATA +: DATA];
    end
  end

endmodule

// File: rtl/ready_pool.sv
// Tagged wait buffer: entries wait for a wakeup tag, then issue lowest-index first.
module ready_pool
  import ready_pool_pkg::*;
#(
  parameter int unsigned DATA  = PkgData,
  parameter int unsigned TAG   = PkgTag,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned IDX   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [DATA-1:0] wr_data,
  input  logic [TAG-1:0]  wr_tag,
  input  logic            wr_rdy,
  input  logic            wk_valid,
  input  logic [TAG-1:0]  wk_tag,
  output logic            iss_valid,
  input  logic            iss_ready,
  output logic [DATA-1:0] iss_data,
  output logic [IDX-1:0]  iss_idx,
  output logic [IDX:0]    count
);

  localparam logic [IDX:0] CntOne = 1;

  entry_t              r_ent   [DEPTH];
  entry_t              w_ent_d [DEPTH];
  logic [IDX:0]        r_count;
  logic [IDX:0]        w_count_d;
  logic [DEPTH-1:0]    w_req;
  logic [DEPTH-1:0]    w_free;
  logic [DEPTH-1:0]    w_iss_pos;
  logic [DEPTH-1:0]    w_alloc_pos;
  logic [DEPTH*DATA-1:0] w_data_flat;
  logic                w_wr_fire;
  logic                w_iss_fire;
  logic                w_wr_woken;
  logic                w_free_data_unused;
  logic [IDX-1:0]      w_iss_idx;

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_req[i]                   = r_ent[i].vld & r_ent[i].rdy;
      w_free[i]                  = ~r_ent[i].vld;
      w_data_flat[i*DATA +: DATA] = DATA'(r_ent[i].data);
    end
  end

  selector #(
    .BIT_MAP (Enable),
    .ACT     (High),
    .MSB     (Disable),
    .DATA    (DATA),
    .IN      (DEPTH)
  ) u_iss_sel (
    .i_req   (w_req),
    .i_data  (w_data_flat),
    .o_pos   (w_iss_pos),
    .o_valid (iss_valid),
    .o_data  (iss_data)
  );

  // Free-slot pick; its valid doubles as "not all slots occupied".
  selector #(
    .BIT_MAP (Enable),
    .ACT     (High),
    .MSB     (Disable),
    .DATA    (1),
    .IN      (DEPTH)
  ) u_free_sel (
    .i_req   (w_free),
    .i_data  ({DEPTH{1'b0}}),
    .o_pos   (w_alloc_pos),
    .o_valid (wr_ready),
    .o_data  (w_free_data_unused)
  );

  always_comb begin
    w_iss_idx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_iss_pos[i]) w_iss_idx = w_iss_idx | IDX'(i);
    end
  end

  assign iss_idx = w_iss_idx;
  assign count   = r_count;

  assign w_wr_fire  = wr_valid & wr_ready;
  assign w_iss_fire = iss_valid & iss_ready;
  assign w_wr_woken = wr_rdy | (wk_valid & (wk_tag == wr_tag));

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_ent_d[i] = r_ent[i];
      if (wk_valid && r_ent[i].vld && !r_ent[i].rdy && (r_ent[i].tag == PkgTag'(wk_tag))) begin
        w_ent_d[i].rdy = 1'b1;
      end
      if (w_iss_fire && w_iss_pos[i]) begin
        w_ent_d[i].vld = 1'b0;
        w_ent_d[i].rdy = 1'b0;
      end
      // Allocation targets a slot free before this edge, never the one issuing now.
      if (w_wr_fire && w_alloc_pos[i]) begin
        w_ent_d[i].vld  = 1'b1;
        w_ent_d[i].rdy  = w_wr_woken;
        w_ent_d[i].tag  = PkgTag'(wr_tag);
        w_ent_d[i].data = PkgData'(wr_data);
      end
    end
  end

  always_comb begin
    w_count_d = r_count;
    case ({w_wr_fire, w_iss_fire})
      2'b10:   w_count_d = r_count + CntOne;
      2'b01:   w_count_d = r_count - CntOne;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) r_ent[i] <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) r_ent[i] <= w_ent_d[i];
      r_count <= w_count_d;
    end
  end

endmodule

// File: tb/tb_ready_pool.sv
// Scoreboarded bench for ready_pool: directed scenarios plus randomized traffic.
module tb_ready_pool;

  localparam int DATA  = 32;
  localparam int TAG   = 6;
  localparam int DEPTH = 8;
  localparam int IDX   = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            wr_valid = 1'b0;
  logic            wr_ready;
  logic [DATA-1:0] wr_data = '0;
  logic [TAG-1:0]  wr_tag = '0;
  logic            wr_rdy = 1'b0;
  logic            wk_valid = 1'b0;
  logic [TAG-1:0]  wk_tag = '0;
  logic            iss_valid;
  logic            iss_ready = 1'b0;
  logic [DATA-1:0] iss_data;
  logic [IDX-1:0]  iss_idx;
  logic [IDX:0]    count;

  always #5 clk = ~clk;

  ready_pool #(
    .DATA  (DATA),
    .TAG   (TAG),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_tag    (wr_tag),
    .wr_rdy    (wr_rdy),
    .wk_valid  (wk_valid),
    .wk_tag    (wk_tag),
    .iss_valid (iss_valid),
    .iss_ready (iss_ready),
    .iss_data  (iss_data),
    .iss_idx   (iss_idx),
    .count     (count)
  );

  // Reference model: a plain array of slots.
  bit              m_vld  [DEPTH];
  bit              m_rdy  [DEPTH];
  logic [TAG-1:0]  m_tag  [DEPTH];
  logic [DATA-1:0] m_data [DEPTH];

  typedef struct {
    bit              iv;
    int              idx;
    logic [DATA-1:0] d;
    bit              wr;
    int              cnt;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.iv = 1'b0; e.idx = 0; e.d = '0; e.wr = 1'b0; e.cnt = 0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (m_vld[i] && m_rdy[i]) begin
        e.iv = 1'b1; e.idx = i; e.d = m_data[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (m_vld[i]) e.cnt++;
      else e.wr = 1'b1;
    end
    return e;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0; m_rdy[i] = 1'b0; m_tag[i] = '0; m_data[i] = '0;
    end
  endfunction

  function automatic void model_edge(bit wv, logic [DATA-1:0] wd, int wt, bit wr, bit kv,
                                     int kt, bit ir);
    exp_t e;
    int   fr;
    e  = model_out();
    fr = -1;
    for (int i = DEPTH - 1; i >= 0; i--) if (!m_vld[i]) fr = i;
    for (int i = 0; i < DEPTH; i++) begin
      if (kv && m_vld[i] && !m_rdy[i] && m_tag[i] == TAG'(kt)) m_rdy[i] = 1'b1;
    end
    if (ir && e.iv) begin
      m_vld[e.idx] = 1'b0; m_rdy[e.idx] = 1'b0;
    end
    if (wv && fr >= 0) begin
      m_vld[fr]  = 1'b1;
      m_rdy[fr]  = wr || (kv && TAG'(kt) == TAG'(wt));
      m_tag[fr]  = TAG'(wt);
      m_data[fr] = wd;
    end
  endfunction

  // One clock of stimulus; expected outputs for this cycle go to the scoreboard.
  task automatic cyc(input bit wv, input logic [DATA-1:0] wd, input int wt, input bit wr,
                     input bit kv, input int kt, input bit ir);
    wr_valid  = wv;
    wr_data   = wd;
    wr_tag    = TAG'(wt);
    wr_rdy    = wr;
    wk_valid  = kv;
    wk_tag    = TAG'(kt);
    iss_ready = ir;
    q.push_back(model_out());
    @(posedge clk);
    model_edge(wv, wd, wt, wr, kv, kt, ir);
    #1;
  endtask

  task automatic idle(input bit ir);
    cyc(1'b0, '0, 0, 1'b0, 1'b0, 0, ir);
  endtask

  // Reset asserted between edges; outputs must clear before any clock edge.
  task automatic reset_mid();
    wr_valid = 1'b0; wk_valid = 1'b0; iss_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rst_iss_valid", iss_valid, 0);
    chk("rst_iss_data", iss_data, 0);
    chk("rst_iss_idx", iss_idx, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_count", count, 0);
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: compares every cycle's outputs against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("sb_iss_valid", iss_valid, e.iv);
        chk("sb_iss_idx", iss_idx, e.idx);
        chk("sb_iss_data", iss_data, e.d);
        chk("sb_wr_ready", wr_ready, e.wr);
        chk("sb_count", count, e.cnt);
      end
    end
  end

  initial begin
    model_clear();
    #1 reset = 1'b1;
    #2;
    chk("init_iss_valid", iss_valid, 0);
    chk("init_count", count, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Reset with three entries held.
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h5000 + i, i, 1'b1, 1'b0, 0, 1'b0);
    chk("pre_rst_count", count, 3);
    reset_mid();

    // Fill to full, then a 9th write is dropped.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'hA000 + i, 32 + i, 1'b0, 1'b0, 0, 1'b0);
    chk("fill_count", count, 8);
    chk("fill_wr_ready", wr_ready, 0);
    cyc(1'b1, 32'hA0FF, 32, 1'b0, 1'b0, 0, 1'b0);
    chk("ninth_count", count, 8);
    cyc(1'b0, '0, 0, 1'b0, 1'b1, 37, 1'b0);
    chk("fill_order_idx", iss_idx, 5);
    chk("fill_order_data", iss_data, 32'hA005);
    reset_mid();

    // Multi-match wakeup: slots 2 and 5 share tag 0x11, slot 3 waits on 0x12.
    cyc(1'b1, 32'hB000, 'h30, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'hB001, 'h31, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'hB002, 'h11, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'hB003, 'h12, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'hB004, 'h34, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'hB005, 'h11, 1'b0, 1'b0, 0, 1'b0);
    cyc(1'b0, '0, 0, 1'b0, 1'b1, 'h11, 1'b1);
    chk("wk_first_valid", iss_valid, 1);
    chk("wk_first_idx", iss_idx, 2);
    idle(1'b1);
    chk("wk_second_idx", iss_idx, 5);
    idle(1'b1);
    chk("wk_drained", iss_valid, 0);
    idle(1'b1);
    chk("wk_slot3_held", iss_valid, 0);

    // Same-cycle bypass wakeup.
    cyc(1'b1, 32'hC0DE0007, 'h07, 1'b0, 1'b1, 'h07, 1'b0);
    chk("byp_valid", iss_valid, 1);
    chk("byp_data", iss_data, 32'hC0DE0007);
    reset_mid();

    // Write + issue while full: write dropped, then lands in the freed slot.
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'hC000 + i, 32 + i, i == 0, 1'b0, 0, 1'b0);
    cyc(1'b1, 32'hC0FF, 'h3F, 1'b0, 1'b0, 0, 1'b1);
    chk("full_wi_count", count, 7);
    chk("full_wi_wr_ready", wr_ready, 1);
    cyc(1'b1, 32'hC1FF, 'h3F, 1'b0, 1'b0, 0, 1'b0);
    chk("full_refill_count", count, 8);
    cyc(1'b0, '0, 0, 1'b0, 1'b1, 'h3F, 1'b0);
    chk("full_refill_idx", iss_idx, 0);
    chk("full_refill_data", iss_data, 32'hC1FF);
    reset_mid();

    // Backpressure: slot 4 offered and held, then a lower slot takes over.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hD000 + i, 'h10 + i, i == 4, 1'b0, 0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      idle(1'b0);
      chk("bp_hold_idx", iss_idx, 4);
    end
    cyc(1'b0, '0, 0, 1'b0, 1'b1, 'h11, 1'b0);
    chk("bp_switch_idx", iss_idx, 1);
    chk("bp_switch_data", iss_data, 32'hD001);
    reset_mid();

    // Randomized traffic with a small tag space so wakeups hit often.
    for (int n = 0; n < 800; n++) begin
      int rd_pct;
      rd_pct = ((n / 100) % 2 == 0) ? 25 : 75;
      cyc($urandom_range(0, 9) < 6, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) < 4, $urandom_range(0, 3), $urandom_range(0, 99) < rd_pct);
    end
    idle(1'b0);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
